// File: rtl/ifetch.sv
// Instruction fetch: drives a zero-latency instruction memory from a fetch PC and buffers
// {pc, inst} pairs in a small prefetch FIFO presented to decode over valid/ready.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_im_addr,
  input  logic [31:0] i_im_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [31:0]   r_fpc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic w_pop;
  logic w_push;

  assign o_im_addr    = r_fpc;
  assign o_inst_valid = (r_count != '0);

  // Outputs depend only on state, never on i_inst_ready.
  assign o_inst    = o_inst_valid ? r_inst_mem[r_rptr] : 32'h0;
  assign o_inst_pc = o_inst_valid ? r_pc_mem[r_rptr]   : 32'h0;

  assign w_pop  = o_inst_valid & i_inst_ready & ~i_redirect;
  // A full FIFO still accepts the new word when the head leaves in the same cycle.
  assign w_push = ~i_redirect & ((r_count < FullCnt) | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fpc   <= RESET_PC & ~32'h3;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_redirect) begin
      r_fpc   <= i_redirect_pc & ~32'h3;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fpc  <= r_fpc + 32'd4;
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_pc_mem[r_wptr]   <= r_fpc;
      r_inst_mem[r_wptr] <= i_im_data;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: stimulus queues expected {pc, inst} pairs, a negedge
// monitor pops and compares on every accepted handshake.
module tb_ifetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  exp_t q[$];
  int   n_pass;
  int   n_total;

  ifetch #(
    .RESET_PC(32'h0000_3000),
    .DEPTH   (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_im_addr    (im_addr),
    .i_im_data    (im_data),
    .o_inst_valid (inst_valid),
    .i_inst_ready (inst_ready),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc)
  );

  // Memory word i (counting from 0x3000) holds 0x1000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a - 32'h0000_3000) >> 2);
  endfunction

  assign im_data = mem_word(im_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.inst = word;
    q.push_back(e);
  endtask

  task automatic drain(input string name, output int n);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    inst_ready = 1'b0;
    chk(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && inst_ready && !redirect) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pop: got pc %h inst %h want none", inst_pc, inst);
      end else begin
        e = q.pop_front();
        if (inst_pc === e.pc && inst === e.inst) n_pass++;
        else $display("FAIL pop: got pc %h inst %h want pc %h inst %h",
                      inst_pc, inst, e.pc, e.inst);
      end
    end
  end

  initial begin
    int n;
    n_pass      = 0;
    n_total     = 0;
    rst         = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    #2;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_im_addr", im_addr, 32'h0000_3000);

    // Sequential fetch: 8 words back to back
    for (int i = 0; i < 8; i++) expect_pc(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    tick();
    rst        = 1'b0;
    inst_ready = 1'b1;
    drain("seq_drain", n);
    chk("seq_no_gap_cycles", 32'(n), 32'd9);

    // Backpressure from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_count_sat", 32'(dut.r_count), 32'd4);
    chk("bp_im_addr_hold", im_addr, 32'h0000_3010);
    chk("bp_head_pc", inst_pc, 32'h0000_3000);
    for (int i = 0; i < 12; i++) expect_pc(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    inst_ready = 1'b1;
    drain("bp_drain", n);
    chk("bp_after_count", 32'(dut.r_count), 32'd4);
    chk("bp_after_im_addr", im_addr, 32'h0000_3040);
    chk("bp_after_head", inst_pc, 32'h0000_3030);

    // Full FIFO, single-cycle ready pulse: push and pop together
    expect_pc(32'h0000_3030, 32'h1000_000C);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("full_pulse_count", 32'(dut.r_count), 32'd4);
    chk("full_pulse_head_pc", inst_pc, 32'h0000_3034);
    chk("full_pulse_head_inst", inst, 32'h1000_000D);
    chk("full_pulse_fpc", im_addr, 32'h0000_3044);
    chk("full_pulse_sb_empty", 32'(q.size()), 32'd0);

    // Redirect with 3 entries buffered and ready high
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    chk("redir_pre_count", 32'(dut.r_count), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3043;
    inst_ready  = 1'b1;
    tick();
    redirect = 1'b0;
    chk("redir_bubble_valid", 32'(inst_valid), 32'd0);
    chk("redir_im_addr", im_addr, 32'h0000_3040);
    expect_pc(32'h0000_3040, 32'h1000_0010);
    expect_pc(32'h0000_3044, 32'h1000_0011);
    expect_pc(32'h0000_3048, 32'h1000_0012);
    tick();
    chk("redir_first_pc", inst_pc, 32'h0000_3040);
    drain("redir_drain", n);

    // Wrap-around of the fetch PC
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    inst_ready  = 1'b1;
    tick();
    redirect = 1'b0;
    expect_pc(32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8));
    expect_pc(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    expect_pc(32'h0000_0000, mem_word(32'h0000_0000));
    expect_pc(32'h0000_0004, mem_word(32'h0000_0004));
    drain("wrap_drain", n);

    // Asynchronous reset between edges with the FIFO half full
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3100;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    chk("arst_pre_count", 32'(dut.r_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_im_addr", im_addr, 32'h0000_3000);
    tick();
    rst        = 1'b0;
    inst_ready = 1'b1;
    expect_pc(32'h0000_3000, 32'h1000_0000);
    expect_pc(32'h0000_3004, 32'h1000_0001);
    expect_pc(32'h0000_3008, 32'h1000_0002);
    drain("arst_resume", n);

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
